// File: rtl/decode_job_arbiter_pkg.sv
// Shared decoder-link constants and the byte-count formulas used by both this
// arbiter and the control node's output counter.
package decode_job_arbiter_pkg;

  localparam logic [7:0] START_DECODING_MSG      = 8'h01;
  localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARB,
    ST_FORWARD,
    ST_RETURN
  } arb_state_t;

  // Command job length in bytes, header included.
  function automatic int job_bytes(input int x, input int z, input int u);
    return 1 + ((x * z + 7) >>> 3) * u;
  endfunction

  // Decoder response length in bytes for one measurement job.
  function automatic int rsp_bytes(input int x, input int z, input int u);
    int corr;
    corr = (x - 1) * z + (x - 1) * z + 1 + x * z;
    return 3 + ((corr + 7) >>> 3) * u;
  endfunction

endpackage

// File: rtl/decode_job_arbiter_rr.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping.
module rr_arbiter #(
  parameter  int N     = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant_onehot,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    found        = 1'b0;
    sum          = '0;
    idx          = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (IDX_W + 1)'(i);
      if (sum >= (IDX_W + 1)'(N)) begin
        sum = sum - (IDX_W + 1)'(N);
      end
      idx = sum[IDX_W-1:0];
      if (!found && req[idx]) begin
        found             = 1'b1;
        grant_onehot[idx] = 1'b1;
        grant_idx         = idx;
      end
    end
  end

endmodule

// File: rtl/decode_job_arbiter.sv
// Shares one decoder byte stream between several host links; a link owns the
// decoder for a whole job (command bytes out, response bytes back).
module decode_job_arbiter
  import decode_job_arbiter_pkg::*;
#(
  parameter  int NUM_REQUESTERS = 2,
  parameter  int GRID_WIDTH_X   = 4,
  parameter  int GRID_WIDTH_Z   = 1,
  parameter  int GRID_WIDTH_U   = 3,
  localparam int ID_W           = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [8*NUM_REQUESTERS-1:0]   req_data,
  input  logic [NUM_REQUESTERS-1:0]     req_valid,
  output logic [NUM_REQUESTERS-1:0]     req_ready,
  output logic [7:0]                    rsp_data,
  output logic [NUM_REQUESTERS-1:0]     rsp_valid,
  input  logic [NUM_REQUESTERS-1:0]     rsp_ready,
  output logic [7:0]                    dec_in_data,
  output logic                          dec_in_valid,
  input  logic                          dec_in_ready,
  input  logic [7:0]                    dec_out_data,
  input  logic                          dec_out_valid,
  output logic                          dec_out_ready,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy,
  output logic                          drop_pulse
);

  // Handshake rule on every port pair: a byte moves on a rising edge where
  // valid and ready are both high; a valid byte stays stable until it moves.

  localparam logic [CNT_W-1:0] JOB_LEN = CNT_W'(job_bytes(GRID_WIDTH_X, GRID_WIDTH_Z, GRID_WIDTH_U));
  localparam logic [CNT_W-1:0] RSP_LEN = CNT_W'(rsp_bytes(GRID_WIDTH_X, GRID_WIDTH_Z, GRID_WIDTH_U));

  arb_state_t        state, state_next;
  logic [ID_W-1:0]   rr_ptr, rr_ptr_next;
  logic [ID_W-1:0]   grant_id_next;
  logic [CNT_W-1:0]  byte_cnt, byte_cnt_next;
  logic              rsp_expect, rsp_expect_next;

  logic [7:0]                  lane_data [NUM_REQUESTERS];
  logic [NUM_REQUESTERS-1:0]   arb_onehot;
  logic [ID_W-1:0]             arb_idx;
  logic                        any_req;
  logic [ID_W-1:0]             ptr_after;
  logic [CNT_W-1:0]            job_len;
  logic [CNT_W-1:0]            cnt_inc;

  for (genvar gi = 0; gi < NUM_REQUESTERS; gi++) begin : g_lane
    assign lane_data[gi] = req_data[8*gi +: 8];
  end

  rr_arbiter #(
    .N (NUM_REQUESTERS)
  ) u_rr (
    .req          (req_valid),
    .ptr          (rr_ptr),
    .grant_onehot (arb_onehot),
    .grant_idx    (arb_idx)
  );

  assign any_req   = |arb_onehot;
  assign ptr_after = (grant_id == ID_W'(NUM_REQUESTERS - 1)) ? '0 : grant_id + 1'b1;
  assign job_len   = rsp_expect ? JOB_LEN : CNT_W'(1);
  assign cnt_inc   = byte_cnt + CNT_W'(1);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      grant_id   <= '0;
      byte_cnt   <= '0;
      rsp_expect <= 1'b0;
    end else begin
      state      <= state_next;
      rr_ptr     <= rr_ptr_next;
      grant_id   <= grant_id_next;
      byte_cnt   <= byte_cnt_next;
      rsp_expect <= rsp_expect_next;
    end
  end

  always_comb begin
    state_next      = state;
    rr_ptr_next     = rr_ptr;
    grant_id_next   = grant_id;
    byte_cnt_next   = byte_cnt;
    rsp_expect_next = rsp_expect;
    req_ready       = '0;
    rsp_valid       = '0;
    rsp_data        = '0;
    dec_in_data     = '0;
    dec_in_valid    = 1'b0;
    dec_out_ready   = 1'b0;
    drop_pulse      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (any_req) begin
          grant_id_next = arb_idx;
          state_next    = ST_ARB;
        end
      end

      // The header is only peeked here; FORWARD sends it as the job's first byte.
      ST_ARB: begin
        if (req_valid[grant_id]) begin
          if (lane_data[grant_id] == START_DECODING_MSG) begin
            rsp_expect_next = 1'b0;
            state_next      = ST_FORWARD;
          end else if (lane_data[grant_id] == MEASUREMENT_DATA_HEADER) begin
            rsp_expect_next = 1'b1;
            state_next      = ST_FORWARD;
          end else begin
            req_ready[grant_id] = 1'b1;
            drop_pulse          = 1'b1;
            rr_ptr_next         = ptr_after;
            state_next          = ST_IDLE;
          end
        end
      end

      ST_FORWARD: begin
        dec_in_data         = lane_data[grant_id];
        dec_in_valid        = req_valid[grant_id];
        req_ready[grant_id] = dec_in_ready;
        if (req_valid[grant_id] && dec_in_ready) begin
          byte_cnt_next = cnt_inc;
          if (cnt_inc == job_len) begin
            if (rsp_expect) begin
              state_next = ST_RETURN;
            end else begin
              rr_ptr_next = ptr_after;
              state_next  = ST_IDLE;
            end
          end
        end
      end

      ST_RETURN: begin
        rsp_data            = dec_out_data;
        rsp_valid[grant_id] = dec_out_valid;
        dec_out_ready       = rsp_ready[grant_id];
        if (dec_out_valid && rsp_ready[grant_id]) begin
          byte_cnt_next = cnt_inc;
          if (cnt_inc == RSP_LEN) begin
            rr_ptr_next = ptr_after;
            state_next  = ST_IDLE;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (state_next != state) begin
      byte_cnt_next = '0;
    end
  end

endmodule

// File: tb/tb_decode_job_arbiter.sv
// Directed bench for decode_job_arbiter: host-link and decoder models run in a
// background loop, scenario tasks load them and compare against fixed values.
module tb_decode_job_arbiter;
  import decode_job_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] req_data = '0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b11;
  logic [7:0]  dec_in_data;
  logic        dec_in_valid;
  logic        dec_in_ready = 1'b1;
  logic [7:0]  dec_out_data = '0;
  logic        dec_out_valid = 1'b0;
  logic        dec_out_ready;
  logic [0:0]  grant_id;
  logic        busy;
  logic        drop_pulse;

  decode_job_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .req_data      (req_data),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .rsp_data      (rsp_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .dec_in_data   (dec_in_data),
    .dec_in_valid  (dec_in_valid),
    .dec_in_ready  (dec_in_ready),
    .dec_out_data  (dec_out_data),
    .dec_out_valid (dec_out_valid),
    .dec_out_ready (dec_out_ready),
    .grant_id      (grant_id),
    .busy          (busy),
    .drop_pulse    (drop_pulse)
  );

  always #5 clk = ~clk;

  // Model state: host byte queues, decoder return queue, observation logs.
  logic [7:0] host_q [2][$];
  logic [7:0] dec_tx [$];
  logic [7:0] dec_rx [$];
  int         dec_rx_cyc [$];
  logic [7:0] rsp_log [2][$];
  int         rsp_cyc [2][$];
  int         cyc = 0;
  int         drop_cnt = 0;
  int         dec_valid_cnt = 0;
  int         rsp1_cnt = 0;
  int         ret_cnt = 0;
  int         mirror_bad = 0;
  int         stall_seen = 0;
  logic       in_toggle = 1'b0;
  int         stall_at = 0;
  int         stall_rem = 0;
  logic [1:0] pop_req;
  logic       pop_tx;

  int n_checks = 0;
  int n_pass = 0;

  always begin
    @(negedge clk);
    pop_req = '0;
    pop_tx  = 1'b0;
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) pop_req[i] = 1'b1;
      end
      if (dec_in_valid && dec_in_ready) begin
        dec_rx.push_back(dec_in_data);
        dec_rx_cyc.push_back(cyc);
      end
      if (dec_out_valid && dec_out_ready) begin
        pop_tx = 1'b1;
        for (int i = 0; i < 2; i++) begin
          if (rsp_valid[i] && rsp_ready[i]) begin
            rsp_log[i].push_back(rsp_data);
            rsp_cyc[i].push_back(cyc);
          end
        end
      end
      if (drop_pulse) drop_cnt++;
      if (dec_in_valid) dec_valid_cnt++;
      if (rsp_valid[1]) rsp1_cnt++;
      if (dut.state == ST_RETURN) begin
        ret_cnt++;
        if (grant_id == 1'b0 && dec_out_ready !== rsp_ready[0]) mirror_bad++;
        if (!rsp_ready[0]) stall_seen++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (pop_req[i] && host_q[i].size() > 0) void'(host_q[i].pop_front());
      req_valid[i]       = (host_q[i].size() > 0);
      req_data[8*i +: 8] = (host_q[i].size() > 0) ? host_q[i][0] : 8'h00;
    end
    if (pop_tx && dec_tx.size() > 0) void'(dec_tx.pop_front());
    dec_out_valid = (dec_tx.size() > 0);
    dec_out_data  = (dec_tx.size() > 0) ? dec_tx[0] : 8'h00;
    dec_in_ready  = in_toggle ? ~dec_in_ready : 1'b1;
    if (stall_rem > 0 && rsp_log[0].size() >= stall_at) begin
      rsp_ready[0] = 1'b0;
      stall_rem--;
    end else begin
      rsp_ready[0] = 1'b1;
    end
    rsp_ready[1] = 1'b1;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    dec_rx.delete();
    dec_rx_cyc.delete();
    for (int i = 0; i < 2; i++) begin
      rsp_log[i].delete();
      rsp_cyc[i].delete();
    end
    drop_cnt = 0;
    dec_valid_cnt = 0;
    rsp1_cnt = 0;
    ret_cnt = 0;
    mirror_bad = 0;
    stall_seen = 0;
  endtask

  task automatic load_meas_job(input int lane, input logic [7:0] base);
    host_q[lane].push_back(MEASUREMENT_DATA_HEADER);
    for (int i = 1; i <= 3; i++) host_q[lane].push_back(8'(base + 8'(i)));
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(host_q[0].size() == 0 && host_q[1].size() == 0 && dec_tx.size() == 0 && !busy) && n < 300);
    n_checks++;
    if (n >= 300) $display("FAIL %s_timeout: busy=%0b after %0d cycles, required idle", tag, busy, n);
    else n_pass++;
  endtask

  task automatic test_reset();
    tick();
    n_checks++;
    if ({req_ready, rsp_valid, dec_in_valid, dec_out_ready} !== 6'b0)
      $display("FAIL reset_handshakes: got %b, required 000000", {req_ready, rsp_valid, dec_in_valid, dec_out_ready});
    else n_pass++;
    n_checks++;
    if ({busy, drop_pulse, grant_id} !== 3'b0)
      $display("FAIL reset_status: got %b, required 000", {busy, drop_pulse, grant_id});
    else n_pass++;
    n_checks++;
    if ({dec_in_data, rsp_data} !== 16'h0)
      $display("FAIL reset_data: got %h, required 0000", {dec_in_data, rsp_data});
    else n_pass++;
    n_checks++;
    if (dut.rr_ptr !== 1'b0) $display("FAIL reset_rr_ptr: got %0d, required 0", dut.rr_ptr);
    else n_pass++;
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic test_single_job();
    logic ok;
    int   s;
    clear_logs();
    load_meas_job(0, 8'hA0);
    for (int i = 0; i < 9; i++) dec_tx.push_back(8'(8'h90 + i));
    @(posedge clk);
    #2;
    s = cyc;
    wait_done("single");
    ok = (dec_rx.size() == 4) && dec_rx[0] == MEASUREMENT_DATA_HEADER && dec_rx[1] == 8'hA1
         && dec_rx[2] == 8'hA2 && dec_rx[3] == 8'hA3;
    n_checks++;
    if (!ok) $display("FAIL single_dec_in: got %0d bytes, required 4 bytes 02 a1 a2 a3", dec_rx.size());
    else n_pass++;
    n_checks++;
    if (dec_rx_cyc.size() == 0 || dec_rx_cyc[0] != s + 2)
      $display("FAIL single_grant_latency: got first byte cycle %0d, required %0d", (dec_rx_cyc.size() > 0) ? dec_rx_cyc[0] : -1, s + 2);
    else n_pass++;
    ok = (rsp_log[0].size() == 9);
    for (int i = 0; i < 9 && ok; i++) if (rsp_log[0][i] !== 8'(8'h90 + i)) ok = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL single_rsp: got %0d bytes on link 0, required 9 bytes 90..98", rsp_log[0].size());
    else n_pass++;
    n_checks++;
    if (rsp1_cnt != 0) $display("FAIL single_rsp_valid1: got %0d cycles high, required 0", rsp1_cnt);
    else n_pass++;
    n_checks++;
    if (dut.rr_ptr !== 1'b1) $display("FAIL single_rr_ptr: got %0d, required 1", dut.rr_ptr);
    else n_pass++;
  endtask

  task automatic test_start_msg();
    int s;
    clear_logs();
    host_q[1].push_back(START_DECODING_MSG);
    @(posedge clk);
    #2;
    s = cyc;
    repeat (4) tick();
    n_checks++;
    if (busy !== 1'b0 || cyc != s + 3) $display("FAIL start_idle: got busy=%0b at cycle %0d, required 0 at %0d", busy, cyc, s + 3);
    else n_pass++;
    n_checks++;
    if (dec_rx.size() != 1 || dec_rx[0] !== START_DECODING_MSG)
      $display("FAIL start_forward: got %0d bytes, required 1 byte 01", dec_rx.size());
    else n_pass++;
    n_checks++;
    if (dec_rx_cyc.size() != 1 || dec_rx_cyc[0] != s + 2)
      $display("FAIL start_fwd_cycle: got %0d, required %0d", (dec_rx_cyc.size() > 0) ? dec_rx_cyc[0] : -1, s + 2);
    else n_pass++;
    n_checks++;
    if (ret_cnt != 0) $display("FAIL start_no_return: got %0d RETURN cycles, required 0", ret_cnt);
    else n_pass++;
    n_checks++;
    if (dut.rr_ptr !== 1'b0 || grant_id !== 1'b1)
      $display("FAIL start_grant: got rr_ptr=%0d grant=%0d, required 0 and 1", dut.rr_ptr, grant_id);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic ok;
    clear_logs();
    load_meas_job(0, 8'hB0);
    load_meas_job(1, 8'hC0);
    for (int i = 0; i < 18; i++) dec_tx.push_back(8'(8'h40 + i));
    wait_done("b2b");
    ok = (dec_rx.size() == 8) && dec_rx[0] == MEASUREMENT_DATA_HEADER && dec_rx[3] == 8'hB3
         && dec_rx[4] == MEASUREMENT_DATA_HEADER && dec_rx[5] == 8'hC1 && dec_rx[7] == 8'hC3;
    n_checks++;
    if (!ok) $display("FAIL b2b_order: got %0d bytes, required link 0 job then link 1 job (8 bytes)", dec_rx.size());
    else n_pass++;
    ok = (rsp_log[0].size() == 9) && (rsp_log[1].size() == 9);
    for (int i = 0; i < 9 && ok; i++) begin
      if (rsp_log[0][i] !== 8'(8'h40 + i) || rsp_log[1][i] !== 8'(8'h49 + i)) ok = 1'b0;
    end
    n_checks++;
    if (!ok) $display("FAIL b2b_rsp: got %0d/%0d bytes, required 9/9 in order", rsp_log[0].size(), rsp_log[1].size());
    else n_pass++;
    n_checks++;
    if (rsp_cyc[0].size() != 9 || dec_rx_cyc.size() != 8 || dec_rx_cyc[4] != rsp_cyc[0][8] + 3)
      $display("FAIL b2b_gap: got header cycle %0d, required last rsp cycle %0d + 3",
               (dec_rx_cyc.size() > 4) ? dec_rx_cyc[4] : -1, (rsp_cyc[0].size() > 8) ? rsp_cyc[0][8] : -1);
    else n_pass++;
  endtask

  task automatic test_drop();
    clear_logs();
    host_q[0].push_back(8'hEE);
    wait_done("drop");
    n_checks++;
    if (drop_cnt != 1) $display("FAIL drop_pulse: got %0d cycles high, required 1", drop_cnt);
    else n_pass++;
    n_checks++;
    if (dec_valid_cnt != 0) $display("FAIL drop_dec_valid: got %0d cycles high, required 0", dec_valid_cnt);
    else n_pass++;
    n_checks++;
    if (dut.rr_ptr !== 1'b1) $display("FAIL drop_rr_ptr: got %0d, required 1", dut.rr_ptr);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic ok;
    clear_logs();
    in_toggle = 1'b1;
    stall_at  = 4;
    stall_rem = 5;
    load_meas_job(0, 8'hD0);
    for (int i = 0; i < 9; i++) dec_tx.push_back(8'(8'h60 + i));
    wait_done("bp");
    in_toggle = 1'b0;
    ok = (dec_rx.size() == 4) && dec_rx[0] == MEASUREMENT_DATA_HEADER && dec_rx[1] == 8'hD1
         && dec_rx[2] == 8'hD2 && dec_rx[3] == 8'hD3;
    n_checks++;
    if (!ok) $display("FAIL bp_dec_in: got %0d bytes, required 4 bytes 02 d1 d2 d3", dec_rx.size());
    else n_pass++;
    ok = (rsp_log[0].size() == 9);
    for (int i = 0; i < 9 && ok; i++) if (rsp_log[0][i] !== 8'(8'h60 + i)) ok = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL bp_rsp: got %0d bytes, required 9 bytes 60..68", rsp_log[0].size());
    else n_pass++;
    n_checks++;
    if (mirror_bad != 0 || stall_seen != 5)
      $display("FAIL bp_mirror: got %0d mismatches and %0d stall cycles, required 0 and 5", mirror_bad, stall_seen);
    else n_pass++;
  endtask

  task automatic test_reset_mid_job();
    logic ok;
    int   n;
    clear_logs();
    load_meas_job(0, 8'hE0);
    n = 0;
    while (dec_rx.size() < 2 && n < 50) begin
      tick();
      n++;
    end
    n_checks++;
    if (dec_rx.size() < 2) $display("FAIL rst_mid_wait: got %0d bytes forwarded, required 2", dec_rx.size());
    else n_pass++;
    @(posedge clk);
    #2;
    reset = 1'b1;
    host_q[0].delete();
    tick();
    n_checks++;
    if ({req_ready, rsp_valid, dec_in_valid, dec_out_ready, busy, drop_pulse, grant_id} !== 9'b0 || {dec_in_data, rsp_data} !== 16'h0)
      $display("FAIL rst_mid_outputs: got %b %h, required all zero",
               {req_ready, rsp_valid, dec_in_valid, dec_out_ready, busy, drop_pulse, grant_id}, {dec_in_data, rsp_data});
    else n_pass++;
    n_checks++;
    if (dut.rr_ptr !== 1'b0) $display("FAIL rst_mid_rr_ptr: got %0d, required 0", dut.rr_ptr);
    else n_pass++;
    tick();
    @(posedge clk);
    #2;
    reset = 1'b0;
    clear_logs();
    load_meas_job(0, 8'hF0);
    for (int i = 0; i < 9; i++) dec_tx.push_back(8'(8'h20 + i));
    wait_done("rst_fresh");
    ok = (dec_rx.size() == 4) && dec_rx[1] == 8'hF1 && dec_rx[3] == 8'hF3 && (rsp_log[0].size() == 9);
    for (int i = 0; i < 9 && ok; i++) if (rsp_log[0][i] !== 8'(8'h20 + i)) ok = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL rst_fresh_job: got %0d fwd / %0d rsp bytes, required 4 / 9", dec_rx.size(), rsp_log[0].size());
    else n_pass++;
    n_checks++;
    if (dut.rr_ptr !== 1'b1) $display("FAIL rst_fresh_rr_ptr: got %0d, required 1", dut.rr_ptr);
    else n_pass++;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    test_single_job();
    test_start_msg();
    test_back_to_back();
    test_drop();
    test_backpressure();
    test_reset_mid_job();
    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/decode_job_arbiter.md
# decode_job_arbiter

Shares one decoder byte stream (the unified controller's `input_data`/`output_data` ports) between `NUM_REQUESTERS` host links. A link is granted for a whole job: its command bytes are forwarded to the decoder, and the decoder's response bytes are routed back to the same link. The block sits between the host-link deserializers and the control node. Grants rotate round-robin.

## Interface
- `NUM_REQUESTERS`, 2: number of host links.
- `GRID_WIDTH_X`, 4: decoder X width.
- `GRID_WIDTH_Z`, 1: decoder Z width.
- `GRID_WIDTH_U`, 3: decoder measurement rounds.
- Derived: `BYTES_PER_ROUND = (X*Z+7)>>3`.
- Derived: `JOB_BYTES = 1 + BYTES_PER_ROUND*U`, which includes the header.
- Derived: `CORR = (X-1)*Z + (X-1)*Z+1 + X*Z`.
- Derived: `RSP_BYTES = 3 + ((CORR+7)>>3)*U`.
- Derived: `ID_W = max(1, clog2(NUM_REQUESTERS))`.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high.
- `req_data` in 8*N: byte lane i at bits [8i+7:8i].
- `req_valid` in N / `req_ready` out N: per-link command handshake.
- `rsp_data` out 8: shared by all links, meaningful only on the granted lane.
- `rsp_valid` out N / `rsp_ready` in N: per-link response handshake.
- `dec_in_data` out 8, `dec_in_valid` out 1, `dec_in_ready` in 1: to the decoder.
- `dec_out_data` in 8, `dec_out_valid` in 1, `dec_out_ready` out 1: from the decoder.
- `grant_id` out ID_W: current or last granted link.
- `busy` out 1: high whenever the arbiter is not in IDLE.
- `drop_pulse` out 1: one-cycle pulse when an unknown header is discarded.

## Operation
- States: IDLE, ARB, FORWARD, RETURN.
- IDLE: all readies and valids are 0.
  - If any `req_valid` is set, the round-robin pick is registered into `grant_id` (search starts at `rr_ptr`) and the state moves to ARB.
- ARB: the header byte of the granted lane is inspected without being consumed.
  - `START_DECODING_MSG`: job length is 1 byte, no response expected. Go to FORWARD.
  - `MEASUREMENT_DATA_HEADER`: job length is `JOB_BYTES`, and `RSP_BYTES` response bytes are expected. Go to FORWARD.
  - Any other byte: assert `req_ready[g]` for one cycle to consume and discard it, pulse `drop_pulse`, advance `rr_ptr`, return to IDLE.
- FORWARD: combinational pass-through.
  - `dec_in_data = req_data[g]`, `dec_in_valid = req_valid[g]`, `req_ready[g] = dec_in_ready`.
  - All other lanes see `req_ready = 0`.
  - `byte_cnt` increments on each transfer.
  - On the transfer that reaches the job length: go to RETURN if a response is expected, otherwise advance `rr_ptr` and go to IDLE.
- RETURN: pass-through in the other direction.
  - `rsp_data = dec_out_data`, `rsp_valid[g] = dec_out_valid`, `dec_out_ready = rsp_ready[g]`.
  - On the `RSP_BYTES`-th transfer: advance `rr_ptr` and go to IDLE.
- `rr_ptr` always advances to `g+1`, wrapping from N-1 to 0.
- Outside RETURN, `dec_out_ready = 0`. An early decoder byte is held at the decoder, never dropped.
- Counters are 16 bits wide. `byte_cnt` clears on every state entry.

## Timing
- Reset values:
  - state IDLE, `rr_ptr` 0, `grant_id` 0, `byte_cnt` 0.
  - All readies and valids 0; `busy` 0; `drop_pulse` 0; `dec_in_data` 0; `rsp_data` 0.
- `reset` asserted mid-job aborts the job immediately. No partial-job recovery is attempted; the decoder is reset alongside.
- Grant latency: 2 cycles from `req_valid` visible in IDLE to the first FORWARD transfer (IDLE→ARB, ARB→FORWARD).
- FORWARD and RETURN sustain 1 byte per cycle and add no pipeline delay.
- A lane that deasserts `req_valid` mid-job stalls the grant. There is no timeout and no pre-emption.
- Simultaneous requests: the lowest index at or above `rr_ptr` wins. A requester that just finished has the lowest priority.
- Return to IDLE costs 1 cycle, so back-to-back jobs have a 3-cycle gap.

## Structure
- `START_DECODING_MSG` and `MEASUREMENT_DATA_HEADER` stay in the shared parameters package.
- The derived byte-count formulas `JOB_BYTES` and `RSP_BYTES` move into that package as functions, so the control node's output counter and this block agree.
- One sub-module, `rr_arbiter`: parameter N.
  - Inputs: `req[N]` and `ptr`.
  - Outputs: `grant_onehot` and `grant_idx`, both combinational.

## Test plan
- Single job, default parameters, link 0 sends 0x?header + 3 measurement bytes:
  - Exactly 4 bytes appear on `dec_in`.
  - The decoder returns 9 bytes; all 9 appear on link 0 with `rsp_valid[1]` = 0 throughout.
  - `rr_ptr` = 1 afterwards.
- Links 0 and 1 request in the same cycle with `rr_ptr` = 0:
  - Link 0 is served first, then link 1.
  - Link 1's header is first seen by the decoder exactly 3 cycles after link 0's last response byte.
- Link 1 sends `START_DECODING_MSG`: 1 byte is forwarded, no RETURN state is entered, and IDLE is reached 1 cycle later.
- Link 0 sends 0xEE (unknown): the byte is consumed, `drop_pulse` is high for 1 cycle, `dec_in_valid` is never asserted, and `rr_ptr` = 1.
- Backpressure: `dec_in_ready` toggles 1/0 and `rsp_ready[0]` is low for 5 cycles mid-response.
  - No byte is lost or duplicated.
  - `dec_out_ready` mirrors `rsp_ready[0]`.
- `reset` asserted during FORWARD after 2 bytes: next cycle all outputs are at reset values, and a fresh job afterwards completes normally.
